// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package memory_bus_pkg;

  localparam int DEF_BUS_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic REQ_INSTR = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Watchdog counter width; kept at least 1 bit so a disabled watchdog still elaborates.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-input grant picker: round-robin against last_grant, or data-first when fixed.
module rr_grant2
  import memory_bus_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_data
);

  always_comb begin
    grant_valid = |req;
    grant_data  = REQ_INSTR;
    case (req)
      2'b10:   grant_data = REQ_DATA;
      2'b11:   grant_data = (FIXED_PRIORITY != 0) ? REQ_DATA : ~last_grant;
      default: grant_data = REQ_INSTR;
    endcase
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one level-request / one-cycle-response memory bus between an instruction
// port and a data port, one transaction at a time, with a stall watchdog.
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [BUS_WIDTH-1:0]  i_write_data,
  output logic [BUS_WIDTH-1:0]  i_read_data,
  output logic                  i_response,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [BUS_WIDTH-1:0]  d_write_data,
  output logic [BUS_WIDTH-1:0]  d_read_data,
  output logic                  d_response,

  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [BUS_WIDTH-1:0]  m_write_data,
  input  logic [BUS_WIDTH-1:0]  m_read_data,
  input  logic                  m_response,

  output logic                  grant_data,
  output logic                  timeout_flag,
  input  logic                  timeout_clear
);

  localparam int              CW       = cnt_width(TIMEOUT_CYCLES);
  localparam int              LIMIT_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0]   WD_LIMIT = CW'(LIMIT_I);
  localparam logic            WD_EN    = (TIMEOUT_CYCLES != 0);

  // Per-port views indexed by requester ID.
  logic [1:0]                 req, wr;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][BUS_WIDTH-1:0]  wdata;
  logic [1:0][BUS_WIDTH-1:0]  rdata_q;
  logic [1:0]                 resp_q;

  state_t        state, state_n;
  logic          last_grant;
  logic          gnt_valid, gnt;
  logic [CW-1:0] wd_cnt;
  logic          wd_expire;

  assign req   = {d_read | d_write, i_read | i_write};
  assign wr    = {d_write, i_write};
  assign addr  = {d_address, i_address};
  assign wdata = {d_write_data, i_write_data};

  assign i_read_data = rdata_q[REQ_INSTR];
  assign d_read_data = rdata_q[REQ_DATA];
  assign i_response  = resp_q[REQ_INSTR];
  assign d_response  = resp_q[REQ_DATA];

  assign wd_expire = WD_EN && (wd_cnt == WD_LIMIT);

  rr_grant2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_grant (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant_data  (gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_valid) state_n = BUSY;
      BUSY:    if (m_response || wd_expire) state_n = RESPOND;
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_write_data <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      grant_data   <= REQ_INSTR;
      last_grant   <= REQ_DATA;
      timeout_flag <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      resp_q <= '0;
      if (timeout_clear) timeout_flag <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          grant_data   <= gnt;
          m_write      <= wr[gnt];
          m_read       <= ~wr[gnt];
          m_address    <= addr[gnt];
          m_write_data <= wdata[gnt];
          wd_cnt       <= '0;
        end
        BUSY: begin
          if (m_response) begin
            m_read              <= 1'b0;
            m_write             <= 1'b0;
            rdata_q[grant_data] <= m_read_data;
            resp_q[grant_data]  <= 1'b1;
          end else if (wd_expire) begin
            // Set overrides a same-cycle clear.
            m_read              <= 1'b0;
            m_write             <= 1'b0;
            rdata_q[grant_data] <= '0;
            resp_q[grant_data]  <= 1'b1;
            timeout_flag        <= 1'b1;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESPOND: last_grant <= grant_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench: round-robin/watchdog instance plus a fixed-priority instance.
module tb_memory_bus_arbiter;

  logic clk, reset;
  int   checks, failures;

  // Instance A: round-robin, watchdog of 8 cycles
  logic        i_read, i_write, i_response, d_read, d_write, d_response;
  logic [31:0] i_address, i_write_data, i_read_data, d_address, d_write_data, d_read_data;
  logic        m_read, m_write, m_response, grant_data, timeout_flag, timeout_clear;
  logic [31:0] m_address, m_write_data, m_read_data;

  // Instance B: fixed priority
  logic        fp_i_read, fp_i_write, fp_i_response, fp_d_read, fp_d_write, fp_d_response;
  logic [31:0] fp_i_address, fp_i_write_data, fp_i_read_data;
  logic [31:0] fp_d_address, fp_d_write_data, fp_d_read_data;
  logic        fp_m_read, fp_m_write, fp_m_response, fp_grant_data, fp_timeout_flag;
  logic [31:0] fp_m_address, fp_m_write_data, fp_m_read_data;

  memory_bus_arbiter #(.BUS_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_write_data(i_write_data),
    .i_read_data(i_read_data), .i_response(i_response),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_write_data(d_write_data),
    .d_read_data(d_read_data), .d_response(d_response),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_response(m_response),
    .grant_data(grant_data), .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
  );

  memory_bus_arbiter #(.BUS_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(1024), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .i_read(fp_i_read), .i_write(fp_i_write), .i_address(fp_i_address), .i_write_data(fp_i_write_data),
    .i_read_data(fp_i_read_data), .i_response(fp_i_response),
    .d_read(fp_d_read), .d_write(fp_d_write), .d_address(fp_d_address), .d_write_data(fp_d_write_data),
    .d_read_data(fp_d_read_data), .d_response(fp_d_response),
    .m_read(fp_m_read), .m_write(fp_m_write), .m_address(fp_m_address), .m_write_data(fp_m_write_data),
    .m_read_data(fp_m_read_data), .m_response(fp_m_response),
    .grant_data(fp_grant_data), .timeout_flag(fp_timeout_flag), .timeout_clear(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; timeout_clear = 1'b0;
    i_read = 0; i_write = 0; i_address = 0; i_write_data = 0;
    d_read = 0; d_write = 0; d_address = 0; d_write_data = 0;
    m_response = 0; m_read_data = 0;
    fp_i_read = 0; fp_i_write = 0; fp_i_address = 0; fp_i_write_data = 0;
    fp_d_read = 0; fp_d_write = 0; fp_d_address = 0; fp_d_write_data = 0;
    fp_m_response = 0; fp_m_read_data = 0;

    // Reset state
    nedge();
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_i_resp", i_response, 0);
    chk("rst_i_rdata", i_read_data, 0);
    chk("rst_grant", grant_data, 0);
    chk("rst_tflag", timeout_flag, 0);
    reset = 1'b0;

    // Contention: instruction wins first, then a repeated contest goes to data
    nedge();
    i_read = 1; i_address = 32'h300;
    d_write = 1; d_address = 32'h200; d_write_data = 32'h12345678;
    nedge();
    chk("c1_m_read", m_read, 1);
    chk("c1_m_write", m_write, 0);
    chk("c1_grant", grant_data, 0);
    chk("c1_addr", m_address, 32'h300);
    m_response = 1; m_read_data = 32'h0000A5A5;
    nedge();
    chk("c1_i_resp", i_response, 1);
    chk("c1_d_resp", d_response, 0);
    chk("c1_i_rdata", i_read_data, 32'h0000A5A5);
    chk("c1_strobe_drop", m_read, 0);
    i_read = 0; m_response = 0;
    nedge();
    chk("c1_i_resp_end", i_response, 0);
    chk("c1_idle", m_write, 0);
    i_read = 1; i_address = 32'h304;
    nedge();
    chk("c2_m_write", m_write, 1);
    chk("c2_m_read", m_read, 0);
    chk("c2_grant", grant_data, 1);
    chk("c2_addr", m_address, 32'h200);
    chk("c2_wdata", m_write_data, 32'h12345678);
    m_response = 1; m_read_data = 32'h0;
    nedge();
    chk("c2_d_resp", d_response, 1);
    chk("c2_i_resp", i_response, 0);
    d_write = 0; m_response = 0;
    nedge();
    nedge();
    chk("c3_m_read", m_read, 1);
    chk("c3_grant", grant_data, 0);
    chk("c3_addr", m_address, 32'h304);
    m_response = 1; m_read_data = 32'h01020304;
    nedge();
    chk("c3_i_resp", i_response, 1);
    chk("c3_i_rdata", i_read_data, 32'h01020304);
    i_read = 0; m_response = 0;
    nedge();

    // Single instruction read
    i_read = 1; i_address = 32'h100;
    nedge();
    chk("s_m_read", m_read, 1);
    chk("s_addr", m_address, 32'h100);
    m_response = 1; m_read_data = 32'hDEADBEEF;
    nedge();
    chk("s_i_resp", i_response, 1);
    chk("s_i_rdata", i_read_data, 32'hDEADBEEF);
    chk("s_d_resp", d_response, 0);
    i_read = 0; m_response = 0; m_read_data = 32'h0;
    nedge();
    chk("s_i_resp_end", i_response, 0);
    chk("s_rdata_hold", i_read_data, 32'hDEADBEEF);

    // Both strobes high on the data port: write wins
    d_read = 1; d_write = 1; d_address = 32'h400; d_write_data = 32'hCAFE0001;
    nedge();
    chk("rw_m_write", m_write, 1);
    chk("rw_m_read", m_read, 0);
    chk("rw_wdata", m_write_data, 32'hCAFE0001);
    m_response = 1; m_read_data = 32'h5555AAAA;
    nedge();
    chk("rw_d_resp", d_response, 1);
    d_read = 0; d_write = 0; m_response = 0;
    nedge();

    // Watchdog: no response for 8 BUSY cycles
    d_read = 1; d_address = 32'h500;
    for (int k = 0; k < 8; k++) begin
      nedge();
      chk($sformatf("wd_busy%0d", k), m_read, 1);
    end
    nedge();
    chk("wd_m_read", m_read, 0);
    chk("wd_d_resp", d_response, 1);
    chk("wd_d_rdata", d_read_data, 0);
    chk("wd_flag", timeout_flag, 1);
    d_read = 0;
    nedge();
    chk("wd_d_resp_end", d_response, 0);
    chk("wd_flag_sticky", timeout_flag, 1);
    timeout_clear = 1;
    nedge();
    chk("wd_flag_clr", timeout_flag, 0);
    timeout_clear = 0;

    // Reset in the middle of BUSY
    i_read = 1; i_address = 32'h600;
    nedge();
    chk("rb_m_read", m_read, 1);
    #1 reset = 1;
    #1 chk("rb_async", m_read, 0);
    nedge();
    chk("rb_no_resp", i_response, 0);
    reset = 0;
    nedge();
    chk("rb_regrant", m_read, 1);
    chk("rb_addr", m_address, 32'h600);
    m_response = 1; m_read_data = 32'h0BADF00D;
    nedge();
    chk("rb_i_resp", i_response, 1);
    chk("rb_i_rdata", i_read_data, 32'h0BADF00D);
    i_read = 0; m_response = 0;
    nedge();

    // Fixed priority: data wins every contest while both keep requesting
    fp_i_read = 1; fp_i_address = 32'h700;
    fp_d_read = 1; fp_d_address = 32'h800;
    for (int n = 0; n < 4; n++) begin
      nedge();
      chk($sformatf("fp_grant%0d", n), fp_grant_data, 1);
      chk($sformatf("fp_addr%0d", n), fp_m_address, 32'h800);
      fp_m_response = 1; fp_m_read_data = 32'hF0000000 + 32'(n);
      nedge();
      chk($sformatf("fp_d_resp%0d", n), fp_d_response, 1);
      chk($sformatf("fp_i_resp%0d", n), fp_i_response, 0);
      chk($sformatf("fp_d_rdata%0d", n), fp_d_read_data, 32'hF0000000 + 32'(n));
      fp_m_response = 0;
      nedge();
    end
    fp_i_read = 0; fp_d_read = 0;
    nedge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Two-requester arbiter that lets an instruction port and a data port share the single request/response memory bus exposed by the processor-ci `Controller`. Sits between a Harvard-style core and the controller's unified memory interface. Handles one transaction at a time with round-robin or fixed priority, and includes a watchdog that completes stalled transactions. Each side uses the level-request / one-cycle-response handshake already used on the core memory bus.

## Interface
Parameters:
- `BUS_WIDTH`, 32: data width of all read/write data buses.
- `ADDR_WIDTH`, 32: address width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit, in cycles, for waiting on `m_response`; 0 disables the watchdog.
- `FIXED_PRIORITY`, 0: 0 selects round-robin; 1 makes the data port always win contention.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `reset`  in  1  asynchronous, active-high reset.
- Instruction port, `i_*` (X = `i`):
  - `X_read`, `X_write`  in  1  request strobes, held high until `X_response`.
  - `X_address`  in  ADDR_WIDTH  request address.
  - `X_write_data`  in  BUS_WIDTH  write data.
  - `X_read_data`  out  BUS_WIDTH  read data, valid while `X_response`=1.
  - `X_response`  out  1  one-cycle completion pulse.
- Data port, `d_*` (X = `d`): same six signals as the instruction port.
- Memory side:
  - `m_read`, `m_write`  out  1  strobes to the controller.
  - `m_address`  out  ADDR_WIDTH  address to the controller.
  - `m_write_data`  out  BUS_WIDTH  write data to the controller.
  - `m_read_data`  in  BUS_WIDTH  read data from the controller.
  - `m_response`  in  1  completion from the controller.
- Status:
  - `grant_data`  out  1  owner of the current or last transaction (0 = instruction, 1 = data).
  - `timeout_flag`  out  1  sticky watchdog flag.
  - `timeout_clear`  in  1  clears `timeout_flag`.

## Operation
- States: IDLE, BUSY, RESPOND.
- Request definition: a port is requesting when `X_read | X_write`.
  - If both strobes are high, the operation is a write and the read is ignored.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesters with `FIXED_PRIORITY`=0: grant the port that did not win the last grant. `last_grant` resets to data, so the instruction port wins the first contest.
  - Both requesters with `FIXED_PRIORITY`=1: grant the data port.
  - On grant: register address, write data, operation, and winner into the `m_*` outputs and `grant_data`; go to BUSY.
- BUSY:
  - `m_read`/`m_write` stay high; the watchdog counter increments each cycle.
  - On `m_response`=1: capture `m_read_data` into the winner's `X_read_data`, clear `m_read`/`m_write` at that edge, and go to RESPOND.
  - If the counter reaches `TIMEOUT_CYCLES`-1 without a response (watchdog enabled): clear `m_*` strobes, load `X_read_data`=0, set `timeout_flag`, and go to RESPOND.
- RESPOND:
  - Winner's `X_response`=1 for exactly one cycle; the other port's response stays 0.
  - Update `last_grant`; go to IDLE.
  - The requester must drop its strobe at the edge ending RESPOND.
- `m_response` arriving in IDLE or RESPOND is ignored.
- `timeout_flag` is cleared by `timeout_clear`. If set and clear occur in the same cycle, set wins.
- `X_read_data` holds its last value outside RESPOND.
- Write transactions also return `X_read_data`; the bench must not check its value for writes.

## Timing
- Reset values (asynchronous, effective immediately): state IDLE, all `m_*` outputs 0, both `X_response` 0, both `X_read_data` 0, `grant_data` 0, `last_grant` data, `timeout_flag` 0, counter 0.
- Reset in the middle of BUSY abandons the transaction with no response pulse.
- Latency, with the request seen high at edge 0:
  - `m_read`/`m_write` are high from the cycle after edge 0.
  - If `m_response` is sampled at edge k, `X_response` is high during cycle k+1.
  - Minimum request-to-response: 2 cycles.
  - Minimum back-to-back spacing per port: 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Watchdog count width is clog2(`TIMEOUT_CYCLES`+1). The counter saturates and never wraps.

## Structure
- Package `memory_bus_pkg`:
  - state encoding constants IDLE/BUSY/RESPOND;
  - requester IDs `REQ_INSTR`=0 and `REQ_DATA`=1;
  - default widths.
- One sub-module, `rr_grant2`: combinational two-input grant picker that takes `last_grant` and `FIXED_PRIORITY`. It is instantiated once.

## Test plan
- Single instruction read to 0x100; memory responds 1 cycle later with 0xDEADBEEF -> `i_response` pulses 1 cycle with `i_read_data`=0xDEADBEEF; `d_response` stays 0.
- Instruction read and data write (address 0x200, data 0x12345678) raised in the same cycle, round-robin -> instruction served first, then `m_write`=1 with 0x200/0x12345678. A repeated simultaneous request is then won by data.
- `FIXED_PRIORITY`=1 with both ports requesting continuously for 4 transactions -> all 4 grants go to data; instruction is starved.
- `TIMEOUT_CYCLES`=8 and memory never responds -> strobes drop after 8 BUSY cycles, `d_response` pulses with 0, `timeout_flag`=1. Pulsing `timeout_clear` returns it to 0.
- Reset asserted during BUSY -> `m_read` goes to 0 immediately and no response pulse occurs. The next request after reset is granted normally.
- Both `d_read` and `d_write` high -> `m_write`=1 and `m_read`=0.
